// File: rtl/sdram_burst_ctrl.sv
// sdram_burst_ctrl
//   Block-refill memory controller sitting behind the instruction cache.
//   A request is latched in IDLE, SDRAM-like row/column timing is applied
//   (open-page policy with precharge/activate/CAS delays), then one cache
//   block is returned as BLOCK_WORDS consecutive words, one per cycle.
//   A free-running refresh timer raises a pending flag that is serviced
//   from IDLE only, so an in-flight burst is never interrupted.
//   The backing array lives here and has a backdoor write port for preload.
//
// Ports
//   Clk           clock
//   Reset         synchronous, active-high
//   ReadRequest   block refill request (held by the cache until the last word)
//   ReadAddress   byte address of the missing word (latched at acceptance)
//   DataOut       burst data word
//   DataReady     DataOut valid this cycle
//   Busy          controller not idle, or refresh pending
//   WriteEnable   backdoor word write strobe
//   WriteAddress  backdoor byte address
//   WriteData     backdoor data
module sdram_burst_ctrl #(
    parameter int BLOCK_WORDS      = 4,
    parameter int MEM_WORDS        = 16384,
    parameter int ROW_WORDS        = 256,
    parameter int T_RCD            = 3,
    parameter int T_CAS            = 2,
    parameter int T_RP             = 2,
    parameter int T_RFC            = 6,
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReadRequest,
    input  logic [31:0] ReadAddress,
    output logic [31:0] DataOut,
    output logic        DataReady,
    output logic        Busy,
    input  logic        WriteEnable,
    input  logic [31:0] WriteAddress,
    input  logic [31:0] WriteData
);

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int RW  = $clog2(ROW_WORDS);
    localparam int RAW = AW - RW;
    localparam int BCW = $clog2(BLOCK_WORDS) + 1;
    localparam int CW  = 8;
    localparam int RCW = $clog2(REFRESH_INTERVAL);

    typedef enum logic [2:0] {
        IDLE, PRECHARGE, ACTIVATE, CAS, BURST, DONE, REFRESH
    } state_t;

    logic [31:0]    mem [MEM_WORDS];

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;        // cycles left in the current timed state
    logic [BCW-1:0] beat_reg;       // beats already issued in this burst
    logic [AW-1:0]  addr_reg;       // word index of the next beat to read
    logic [RAW-1:0] row_reg;        // currently open row
    logic           row_valid_reg;
    logic           ref_path_reg;   // PRECHARGE belongs to a refresh, not a read
    logic [RCW-1:0] ref_cnt_reg;
    logic           pend_reg;       // refresh pending

    logic [AW-1:0]  req_word;
    logic [AW-1:0]  req_base;
    logic [RAW-1:0] req_row;
    logic [AW-1:0]  wr_word;
    logic           unused_addr_bits;

    // Address bits above the array size and the byte offset do not matter.
    assign req_word = ReadAddress[AW+1:2];
    assign req_base = req_word & ~AW'(BLOCK_WORDS - 1);
    assign req_row  = req_word[AW-1:RW];
    assign wr_word  = WriteAddress[AW+1:2];
    assign unused_addr_bits = ^{ReadAddress[31:AW+2], ReadAddress[1:0],
                                WriteAddress[31:AW+2], WriteAddress[1:0]};

    assign Busy = (state_reg != IDLE) || pend_reg;

    // Backdoor write port; a beat reading the same word at the same edge
    // sees the old contents (read-before-write).
    always_ff @(posedge Clk) begin
        if (WriteEnable) begin
            mem[wr_word] <= WriteData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            beat_reg      <= '0;
            addr_reg      <= '0;
            row_reg       <= '0;
            row_valid_reg <= 1'b0;
            ref_path_reg  <= 1'b0;
            ref_cnt_reg   <= '0;
            pend_reg      <= 1'b0;
            DataOut       <= '0;
            DataReady     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pend_reg) begin
                        ref_path_reg <= 1'b1;
                        if (row_valid_reg) begin
                            state_reg <= PRECHARGE;
                            cnt_reg   <= CW'(T_RP - 1);
                        end else begin
                            state_reg <= REFRESH;
                            cnt_reg   <= CW'(T_RFC - 1);
                        end
                    end else if (ReadRequest) begin
                        ref_path_reg  <= 1'b0;
                        addr_reg      <= req_base;
                        row_reg       <= req_row;
                        row_valid_reg <= 1'b1;
                        if (row_valid_reg && (req_row == row_reg)) begin
                            state_reg <= CAS;
                            cnt_reg   <= CW'(T_CAS - 1);
                        end else if (row_valid_reg) begin
                            state_reg <= PRECHARGE;
                            cnt_reg   <= CW'(T_RP - 1);
                        end else begin
                            state_reg <= ACTIVATE;
                            cnt_reg   <= CW'(T_RCD - 1);
                        end
                    end
                end
                PRECHARGE: begin
                    if (cnt_reg == '0) begin
                        if (ref_path_reg) begin
                            state_reg <= REFRESH;
                            cnt_reg   <= CW'(T_RFC - 1);
                        end else begin
                            state_reg <= ACTIVATE;
                            cnt_reg   <= CW'(T_RCD - 1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ACTIVATE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= CAS;
                        cnt_reg   <= CW'(T_CAS - 1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                CAS: begin
                    if (cnt_reg == '0) begin
                        state_reg <= BURST;
                        DataOut   <= mem[addr_reg];
                        DataReady <= 1'b1;
                        addr_reg  <= addr_reg + 1'b1;
                        beat_reg  <= BCW'(1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                BURST: begin
                    if (beat_reg == BCW'(BLOCK_WORDS)) begin
                        state_reg <= DONE;
                        DataReady <= 1'b0;
                    end else begin
                        DataOut  <= mem[addr_reg];
                        addr_reg <= addr_reg + 1'b1;
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Swallows the cycle in which the cache's registered
                    // request is still high after the last beat.
                    state_reg <= IDLE;
                end
                REFRESH: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= IDLE;
                        row_valid_reg <= 1'b0;
                        pend_reg      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Placed after the FSM so a timer expiry on the same edge as a
            // refresh completion keeps the new request pending.
            if (ref_cnt_reg == RCW'(REFRESH_INTERVAL - 1)) begin
                ref_cnt_reg <= '0;
                pend_reg    <= 1'b1;
            end else begin
                ref_cnt_reg <= ref_cnt_reg + 1'b1;
            end
        end
    end

endmodule
